// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM encoding and port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DMA  = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the port that was not served last wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0] && (!req_i[1] || last_i)) begin
            gnt_o[0] = 1'b1;
        end else if (req_i[1]) begin
            gnt_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port main memory between the core (port 0) and the
// loader/debug DMA (port 1), with bounded locking and read-return routing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [DATA_W-1:0] wdat0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdat0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wdat1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdat1,
    output logic              lock_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdat,
    input  logic [DATA_W-1:0] mem_rdat
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]       block_q, block_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic             lock_err_q, lock_err_d;
    logic [1:0]       rr_gnt;
    logic [1:0]       gnt;

    rr_pick2 u_pick (
        .req_i  ({req1, req0}),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A timeout that coincides with the owner dropping its lock is a plain release.
    always_comb begin
        state_d    = state_q;
        lock_err_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (gnt[PORT_CORE] && lock0 && !block_q[PORT_CORE]) begin
                    state_d = ARB_OWN0;
                end else if (gnt[PORT_DMA] && lock1 && !block_q[PORT_DMA]) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                if (!lock0) begin
                    state_d = ARB_IDLE;
                end else if (lock_cnt_q == CNT_LAST) begin
                    state_d    = ARB_IDLE;
                    lock_err_d = 1'b1;
                end
            end
            ARB_OWN1: begin
                if (!lock1) begin
                    state_d = ARB_IDLE;
                end else if (lock_cnt_q == CNT_LAST) begin
                    state_d    = ARB_IDLE;
                    lock_err_d = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (state_q)
                ARB_IDLE: gnt = rr_gnt;
                ARB_OWN0: gnt[PORT_CORE] = req0;
                ARB_OWN1: gnt[PORT_DMA]  = req1;
                default:  gnt = 2'b00;
            endcase
        end
    end

    // A timed-out port stays unable to relock until it lets go of its lock line.
    always_comb begin
        last_d = last_q;
        if (gnt[PORT_CORE]) begin
            last_d = 1'b0;
        end else if (gnt[PORT_DMA]) begin
            last_d = 1'b1;
        end
        lock_cnt_d = '0;
        if (state_q != ARB_IDLE && state_d == state_q) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
        block_d[PORT_CORE] = lock0 &
            (block_q[PORT_CORE] | (lock_err_d & (state_q == ARB_OWN0)));
        block_d[PORT_DMA]  = lock1 &
            (block_q[PORT_DMA]  | (lock_err_d & (state_q == ARB_OWN1)));
        rvalid_d = {gnt[PORT_DMA] & ~we1, gnt[PORT_CORE] & ~we0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            block_q    <= 2'b00;
            rvalid_q   <= 2'b00;
            lock_err_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            block_q    <= block_d;
            rvalid_q   <= rvalid_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign gnt0     = gnt[PORT_CORE];
    assign gnt1     = gnt[PORT_DMA];
    assign mem_en   = |gnt;
    assign mem_we   = gnt[PORT_DMA] ? we1 : (gnt[PORT_CORE] ? we0 : 1'b0);
    assign mem_adr  = gnt[PORT_DMA] ? adr1  : adr0;
    assign mem_wdat = gnt[PORT_DMA] ? wdat1 : wdat0;
    assign rvalid0  = rvalid_q[PORT_CORE];
    assign rvalid1  = rvalid_q[PORT_DMA];
    assign rdat0    = mem_rdat;
    assign rdat1    = mem_rdat;
    assign lock_err = lock_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 1-cycle memory, directed sequences and a
// read-return scoreboard fed from the requester side of each granted read.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] wdat0, wdat1;
    logic          gnt0, gnt1, rvalid0, rvalid1, lock_err;
    logic [DW-1:0] rdat0, rdat1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
    } rd_exp_t;

    rd_exp_t       q0[$];
    rd_exp_t       q1[$];
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .adr0(adr0), .wdat0(wdat0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdat0(rdat0),
        .req1(req1), .we1(we1), .lock1(lock1), .adr1(adr1), .wdat1(wdat1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdat1(rdat1),
        .lock_err(lock_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (mem_en) begin
            if (mem_we) mem[mem_adr[7:0]] <= mem_wdat;
            else        mem_rdat <= mem[mem_adr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each granted read must come back exactly one cycle later; any other rvalid is spurious.
    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() > 0 && q0[0].cyc == cyc - 1) begin
                chk("rvalid0", rvalid0, 1);
                if (rvalid0) chk("rdat0", rdat0, q0[0].d);
                void'(q0.pop_front());
            end else begin
                chk("rvalid0_idle", rvalid0, 0);
            end
            if (q1.size() > 0 && q1[0].cyc == cyc - 1) begin
                chk("rvalid1", rvalid1, 1);
                if (rvalid1) chk("rdat1", rdat1, q1[0].d);
                void'(q1.pop_front());
            end else begin
                chk("rvalid1_idle", rvalid1, 0);
            end
            if (gnt0) begin
                if (we0) ref_mem[adr0[7:0]] = wdat0;
                else     q0.push_back('{cyc: cyc, d: ref_mem[adr0[7:0]]});
            end
            if (gnt1) begin
                if (we1) ref_mem[adr1[7:0]] = wdat1;
                else     q1.push_back('{cyc: cyc, d: ref_mem[adr1[7:0]]});
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 3);
            ref_mem[i] = 16'(i * 3);
        end
        mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
        mem[8'h30] = 16'h5555; ref_mem[8'h30] = 16'h5555;
        mem[8'h31] = 16'hAAAA; ref_mem[8'h31] = 16'hAAAA;
        mem_rdat = '0;
        reset = 1'b1;
        {req0, we0, lock0, req1, we1, lock1} = '0;
        adr0 = '0; adr1 = '0; wdat0 = '0; wdat1 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 0);
        chk("rst_lock_err", lock_err, 0);
        tick();
        reset = 1'b0;

        // single read from the core
        req0 = 1; we0 = 0; adr0 = 16'h0010;
        @(negedge clk);
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_adr", mem_adr, 16'h0010);
        tick();
        req0 = 0;
        @(negedge clk);
        chk("t1_rdat0", rdat0, 16'hBEEF);
        chk("t1_gnt1_after", gnt1, 0);

        // port 1 alone first so the tie sequence starts with port 0
        tick();
        req1 = 1; we1 = 0; adr1 = 16'h0010;
        @(negedge clk);
        chk("t2_pre_gnt1", gnt1, 1);
        tick();
        req0 = 1; adr0 = 16'h0030; adr1 = 16'h0031;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_gnt0", gnt0, (i % 2 == 0));
            chk("t2_gnt1", gnt1, (i % 2 == 1));
            tick();
        end
        req0 = 0; req1 = 0;

        // locked write-then-read by port 1 while port 0 keeps requesting
        req1 = 1; we1 = 1; lock1 = 1; adr1 = 16'h0020; wdat1 = 16'h1234;
        @(negedge clk);
        chk("t3_wr_gnt1", gnt1, 1);
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_adr", mem_adr, 16'h0020);
        chk("t3_mem_wdat", mem_wdat, 16'h1234);
        tick();
        we1 = 0; req0 = 1; adr0 = 16'h0010;
        @(negedge clk);
        chk("t3_own_gnt1", gnt1, 1);
        chk("t3_own_gnt0", gnt0, 0);
        chk("t3_no_wr_rvalid", rvalid1, 0);
        tick();
        lock1 = 0;
        @(negedge clk);
        chk("t3_rel_gnt1", gnt1, 1);
        chk("t3_rel_gnt0", gnt0, 0);
        tick();
        req1 = 0;
        @(negedge clk);
        chk("t3_after_gnt0", gnt0, 1);
        tick();
        req0 = 0;
        tick();

        // lock timeout on port 0
        for (int i = 0; i < 12; i++) begin
            req0 = 1; we0 = 0; lock0 = 1; adr0 = 16'h0010;
            req1 = (i != 0 && i != 10); adr1 = 16'h0031;
            @(negedge clk);
            chk("t4_lock_err", lock_err, (i == 9));
            chk("t4_gnt0", gnt0, !(i == 9 || i == 11));
            chk("t4_gnt1", gnt1, (i == 9 || i == 11));
            tick();
        end
        req1 = 0; lock0 = 0;
        @(negedge clk);
        chk("t4_unlock_gnt0", gnt0, 1);
        tick();
        lock0 = 1;
        @(negedge clk);
        chk("t4_relock_gnt0", gnt0, 1);
        tick();
        req1 = 1;
        @(negedge clk);
        chk("t4_relocked_gnt0", gnt0, 1);
        chk("t4_relocked_gnt1", gnt1, 0);

        // reset while owned with a read in flight
        tick();
        reset = 1;
        @(negedge clk);
        chk("t5_rst_rvalid0", rvalid0, 0);
        chk("t5_rst_gnt0", gnt0, 0);
        chk("t5_rst_lock_err", lock_err, 0);
        tick();
        reset = 0; lock0 = 0;
        @(negedge clk);
        chk("t5_tie_gnt0", gnt0, 1);
        chk("t5_tie_gnt1", gnt1, 0);
        tick();
        @(negedge clk);
        chk("t5_idle_gnt1", gnt1, 1);
        tick();
        req0 = 0; req1 = 0;

        // idle bus
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_mem_en", mem_en, 0);
            chk("t6_mem_we", mem_we, 0);
            tick();
        end
        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port main memory between two requesters: port 0 is the core's load/store path and port 1 is the loader/debug DMA that fills and inspects memory. The arbiter uses round-robin arbitration, with an optional per-requester lock for atomic read-modify-write sequences, bounded by a timeout. It sits between the core/loader and the synchronous main-memory macro, whose read latency is one cycle. It owns read-data return routing.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
LOCK_MAX, 8, max consecutive cycles a lock may be held (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req0  in  1  port 0 access request
we0  in  1  port 0 write (1) / read (0)
lock0  in  1  port 0 requests to keep ownership after this grant
adr0  in  ADDR_W  port 0 address
wdat0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 access accepted this cycle
rvalid0  out  1  port 0 read data valid
rdat0  out  DATA_W  port 0 read data
req1, we1, lock1, adr1, wdat1, gnt1, rvalid1, rdat1: same as port 0, for port 1
lock_err  out  1  one-cycle pulse: lock forcibly released by timeout
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_adr  out  ADDR_W  memory address
mem_wdat  out  DATA_W  memory write data
mem_rdat  in  DATA_W  memory read data, valid the cycle after a read strobe

Behaviour:
- Clock is clk. Reset is asynchronous and active-high, named reset. While reset=1: state=IDLE, last=1, lock_cnt=0, rvalid0/1=0, lock_err=0, gnt0/1=0, mem_en=0, mem_we=0.
- Grant is combinational, same cycle as req. At most one gntX=1 per cycle. A request with gntX=0 must be held stable by its requester.
- mem_en = gnt0|gnt1. mem_we, mem_adr and mem_wdat are muxed from the granted port. When no port is granted, mem_adr/mem_wdat are don't-care and mem_we=0.
- Read return: a granted read sets owner tag and rvalidX=1 on the next edge, for exactly one cycle. rdatX = mem_rdat, qualified by rvalidX; rdat of the non-owner is don't-care. Writes produce no rvalid. Back-to-back reads from either port are allowed every cycle.
- FSM states:
  - IDLE: one requester -> grant it. Both -> grant the port != last. last updates to the granted port. If the granted port also has lockX=1 -> OWNX next, lock_cnt=0.
  - OWN0 / OWN1: only the owner is eligible; the other gnt=0 even if it requests. The owner is granted whenever reqX=1. lock_cnt increments each cycle in OWNX.
  - Owner lockX=0 -> IDLE next edge; arbitration in that cycle is still owner-only.
  - lock_cnt == LOCK_MAX-1 with lockX still 1 -> forced IDLE next edge, lock_err=1 for one cycle, last=X. Lock is then ignored for port X (blockX flag) until lockX is seen low.
- Lock asserted without req, or without grant, has no effect.
- lock_err is registered; simultaneous timeout and owner release counts as release, with no lock_err.
- Reset mid-read drops the pending rvalid. Reset in OWNX returns to IDLE.

Decomposition:
- Package mem_arb_pkg: FSM state enum (ARB_IDLE, ARB_OWN0, ARB_OWN1) and port-index constants.
- One sub-module is natural: rr_pick2. It is a combinational 2-way round-robin picker with inputs req[1:0] and last, and outputs a one-hot grant.
- FSM, lock counter, block flags and return tagging stay in mem_arbiter.

Test Plan:
- Reset release, req0 read adr 0x0010, mem holds 0xBEEF -> gnt0 same cycle, rvalid0=1 and rdat0=0xBEEF the next cycle, gnt1/rvalid1 stay 0.
- req0 and req1 held together for 4 cycles, both reads -> grants alternate 0,1,0,1; each rvalid follows its own grant by one cycle with the correct data.
- req1 write adr 0x0020 data 0x1234 with lock1=1, then read 0x0020; req0 active throughout -> gnt0=0 while OWN1. After lock1 drops, port 0 is granted the following cycle; no rvalid1 for the write cycle.
- lock0 held with req0 for 10 cycles, LOCK_MAX=8 -> lock_err pulses once after 8 owned cycles. Port 1 is granted at the next tie, and port 0 cannot relock until lock0 goes low.
- Assert reset for one cycle while a read is in flight and OWN0 is active -> rvalid0=0 the next cycle, state IDLE, and tie-break favours port 0 afterwards.
- Idle (no req) -> mem_en=0, mem_we=0 every cycle, and no rvalid ever asserts.
